// File: rtl/sentence_matcher.sv
// sentence_matcher: matches one byte stream against N fixed L-character reference strings in parallel.
// Optional feature: define SENTENCE_MATCHER_WILDCARD_EN so that a "?" in REFS matches any data byte.
module sentence_matcher #(
  parameter int N = 3,
  parameter int L = 5,
  parameter logic [N*L*8-1:0] REFS = {"GPZDA", "GPGGA", "GPRMC"},
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          restart,
  input  logic          load,
  input  logic [7:0]    data,
  output logic          resolve,
  output logic          reject,
  output logic [IW-1:0] match_index,
  output logic [N-1:0]  match_mask
);

  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam logic [PW-1:0] LAST = PW'(L - 1);

  typedef enum logic [1:0] {MATCHING, RESOLVED, REJECTED} state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [N-1:0]  alive;
  logic [N-1:0]  alive_next;
  logic [IW-1:0] first_idx;
  logic [7:0]    ref_ch;
  logic          hit;

  // Channel c keeps living only while every byte so far equals its reference character.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    alive_next = '0;
    ref_ch     = '0;
    hit        = 1'b0;
    for (int c = 0; c < N; c++) begin
      ref_ch = REFS[(N - c) * L * 8 - 1 - 8 * int'(pos) -: 8];
      hit    = (data == ref_ch);
`ifdef SENTENCE_MATCHER_WILDCARD_EN
      if (ref_ch == 8'h3F) hit = 1'b1;
`endif
      alive_next[c] = alive[c] & hit;
    end
  end

  // Scan from the top so the lowest surviving channel wins.
  always_comb begin
    first_idx = '0;
    for (int c = N - 1; c >= 0; c--) begin
      if (alive_next[c]) first_idx = IW'(c);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= MATCHING;
      pos         <= '0;
      alive       <= '1;
      resolve     <= 1'b0;
      reject      <= 1'b0;
      match_index <= '0;
      match_mask  <= '0;
    end else if (restart) begin
      state       <= MATCHING;
      pos         <= '0;
      alive       <= '1;
      resolve     <= 1'b0;
      reject      <= 1'b0;
      match_index <= '0;
      match_mask  <= '0;
    end else begin
      case (state)
        MATCHING: begin
          if (load) begin
            alive <= alive_next;
            if (alive_next == '0) begin
              state  <= REJECTED;
              reject <= 1'b1;
            end else if (pos == LAST) begin
              state       <= RESOLVED;
              resolve     <= 1'b1;
              match_mask  <= alive_next;
              match_index <= first_idx;
            end else begin
              pos <= pos + 1'b1;
            end
          end
        end
        default: ;  // decided states hold until restart or reset
      endcase
    end
  end

endmodule

// File: doc/sentence_matcher.md
# sentence_matcher

Multi-channel successor to the single-string byte comparer used in the GPZDA sentence front end. It compares one loaded byte stream against N fixed reference strings of length L in parallel and reports which channel(s) matched, or rejects as soon as no channel can still match. It sits after the NMEA character receiver and selects the sentence type (e.g. GPZDA/GPGGA/GPRMC) for the downstream field parsers.

## Interface
- N, default 3: number of reference channels, ≥1.
- L, default 5: characters per reference string, ≥1.
- REFS, default {"GPZDA","GPGGA","GPRMC"}: N*L*8-bit packed string. Channel c, character k sits at bits [(N-c)*L*8-1-8k -: 8]; channel 0 is leftmost.
- IW, derived: max(1, $clog2(N)).

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous sentence restart, active high.
- load  in  1  data byte valid this cycle.
- data  in  8  incoming character.
- resolve  out  1  sticky; full L-byte match on ≥1 channel.
- reject  out  1  sticky; no channel can match.
- match_index  out  IW  lowest matching channel; valid only while resolve=1, else 0.
- match_mask  out  N  bit c set = channel c matched; valid only while resolve=1, else 0.

## Operation
- State: MATCHING, RESOLVED, REJECTED; position counter pos (0..L-1, width max(1,$clog2(L))); alive[N-1:0].
- Reset (reset_n=0, async) or restart=1 at an edge: state=MATCHING, pos=0, alive=all ones, resolve=0, reject=0, match_index=0, match_mask=0.
- MATCHING, load=1: alive_next[c] = alive[c] & (data == REFS char pos of channel c). pos increments.
  - alive_next == 0 → REJECTED, reject=1 (early reject, any pos).
  - else if pos == L-1 → RESOLVED, resolve=1, match_mask=alive_next, match_index=lowest set bit of alive_next.
  - else stay MATCHING.
- MATCHING, load=0: no change; data ignored.
- RESOLVED / REJECTED: all loads ignored; outputs held until restart or reset.
- restart and load in the same cycle: restart wins, byte discarded.
- resolve and reject never both 1.
- L=1: first loaded byte decides. N=1: match_index constant 0.

## Timing
- All outputs registered; every output is 0 from reset.
- Decision latency 1 cycle: resolve/reject become visible in the cycle after the edge sampling the deciding byte.
- No back-pressure; one byte per cycle accepted at full rate; load gaps of any length allowed.
- reset_n assertion clears outputs immediately (not edge-dependent); deassertion is synchronised externally.

## Configuration
- SENTENCE_MATCHER_WILDCARD_EN defined: a reference character equal to "?" (8'h3F) matches any data byte on that channel and position.
- Undefined: "?" is a literal; compare is exact 8-bit equality only.

## Test plan
- Defaults; reset_n low → all outputs 0; release, load G,P,Z,D,A on consecutive cycles → cycle after "A": resolve=1, reject=0, match_index=0, match_mask=3'b001; further load "X" → outputs unchanged.
- Load G,P,X → reject=1 the cycle after "X" (pos 2), resolve=0, match_mask=0; subsequent R,M,C ignored.
- Load G,P then restart, then G,P,R,M,C with load=0 cycles and garbage data ("a","b") between bytes → resolve=1, match_index=2, match_mask=3'b100.
- restart=1 together with load=1, data="G", then P,Z,D,A → byte "G" discarded, reject=1 after "P"; assert reset_n=0 mid-sentence → all outputs 0 without a clock edge.
- REFS={"GPZDA","GP?DA","GPRMC"}, load G,P,Z,D,A → with SENTENCE_MATCHER_WILDCARD_EN: match_mask=3'b011, match_index=0; without: match_mask=3'b001, match_index=0.
- N=1, L=1, REFS="$": load "$" → resolve=1, match_index=0; restart, load "!" → reject=1.
